// File: rtl/keypad_matrix_emulator_if.sv
// Command handshake between a keypad driver (master) and the keypad emulator (slave).
interface keypad_matrix_emulator_if;
  logic       cmdValid;
  logic       cmdPress;
  logic [3:0] cmdKey;
  logic       cmdReady;
  logic       cmdErr;

  modport master (output cmdValid, cmdPress, cmdKey, input cmdReady, cmdErr);
  modport slave  (input cmdValid, cmdPress, cmdKey, output cmdReady, cmdErr);
endinterface

// File: rtl/keypad_matrix_emulator.sv
// 4x4 hex keypad stand-in: answers column scans on the row lines and
// replays deterministic contact bounce on every press and release.
module keypad_matrix_emulator #(
  parameter int BOUNCE_PERIOD = 8,
  parameter int BOUNCE_COUNT  = 5
) (
  input  logic                     clk,
  input  logic                     nreset,
  keypad_matrix_emulator_if.slave  cmd,
  input  logic [3:0]               cols,
  output logic [3:0]               rows,
  output logic                     keyActive,
  output logic [3:0]               heldKey,
  output logic                     busy
);

  localparam int CYC_W = (BOUNCE_PERIOD < 1) ? 1 : $clog2(BOUNCE_PERIOD + 1);
  localparam int INT_W = (BOUNCE_COUNT  < 1) ? 1 : $clog2(BOUNCE_COUNT + 1);
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'((BOUNCE_PERIOD < 1) ? 0 : BOUNCE_PERIOD - 1);
  localparam logic [INT_W-1:0] INT_LAST = INT_W'((BOUNCE_COUNT  < 1) ? 0 : BOUNCE_COUNT - 1);

  localparam logic [1:0] IDLE           = 2'd0;
  localparam logic [1:0] PRESS_BOUNCE   = 2'd1;
  localparam logic [1:0] HELD           = 2'd2;
  localparam logic [1:0] RELEASE_BOUNCE = 2'd3;

  logic [1:0]       state;
  logic [CYC_W-1:0] cycCnt;
  logic [INT_W-1:0] intCnt;
  logic             errPulse;
  logic             accept;
  logic             contact;
  logic [1:0]       keyRow;
  logic [1:0]       keyCol;

  assign busy         = (state == PRESS_BOUNCE) || (state == RELEASE_BOUNCE);
  assign cmd.cmdReady = !busy;
  assign cmd.cmdErr   = errPulse;
  assign accept       = cmd.cmdValid && !busy;
  assign keyActive    = contact;

  // Bounce intervals alternate starting from the new contact state, so the
  // first interval already shows the requested edge.
  always_comb begin
    contact = 1'b0;
    case (state)
      IDLE:           contact = 1'b0;
      PRESS_BOUNCE:   contact = ~intCnt[0];
      HELD:           contact = 1'b1;
      RELEASE_BOUNCE: contact = intCnt[0];
      default:        contact = 1'b0;
    endcase
  end

  always_comb begin
    keyRow = 2'd0;
    keyCol = 2'd0;
    case (heldKey)
      4'h1: begin keyRow = 2'd0; keyCol = 2'd0; end
      4'h2: begin keyRow = 2'd0; keyCol = 2'd1; end
      4'h3: begin keyRow = 2'd0; keyCol = 2'd2; end
      4'hA: begin keyRow = 2'd0; keyCol = 2'd3; end
      4'h4: begin keyRow = 2'd1; keyCol = 2'd0; end
      4'h5: begin keyRow = 2'd1; keyCol = 2'd1; end
      4'h6: begin keyRow = 2'd1; keyCol = 2'd2; end
      4'hB: begin keyRow = 2'd1; keyCol = 2'd3; end
      4'h7: begin keyRow = 2'd2; keyCol = 2'd0; end
      4'h8: begin keyRow = 2'd2; keyCol = 2'd1; end
      4'h9: begin keyRow = 2'd2; keyCol = 2'd2; end
      4'hC: begin keyRow = 2'd2; keyCol = 2'd3; end
      4'hE: begin keyRow = 2'd3; keyCol = 2'd0; end
      4'h0: begin keyRow = 2'd3; keyCol = 2'd1; end
      4'hF: begin keyRow = 2'd3; keyCol = 2'd2; end
      4'hD: begin keyRow = 2'd3; keyCol = 2'd3; end
      default: begin keyRow = 2'd0; keyCol = 2'd0; end
    endcase
  end

  // Zero-latency path like a real switch matrix; only the key's own column matters.
  always_comb begin
    rows = 4'b1111;
    if (contact && !cols[keyCol]) begin
      rows[keyRow] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state    <= IDLE;
      cycCnt   <= '0;
      intCnt   <= '0;
      heldKey  <= 4'h0;
      errPulse <= 1'b0;
    end else begin
      errPulse <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (cmd.cmdPress) begin
              heldKey <= cmd.cmdKey;
              cycCnt  <= '0;
              intCnt  <= '0;
              state   <= (BOUNCE_COUNT == 0) ? HELD : PRESS_BOUNCE;
            end else begin
              errPulse <= 1'b1;
            end
          end
        end
        HELD: begin
          if (accept) begin
            if (cmd.cmdPress) begin
              errPulse <= 1'b1;
            end else begin
              cycCnt <= '0;
              intCnt <= '0;
              state  <= (BOUNCE_COUNT == 0) ? IDLE : RELEASE_BOUNCE;
            end
          end
        end
        PRESS_BOUNCE, RELEASE_BOUNCE: begin
          // Comparisons use >= so a corrupted counter still terminates the phase.
          if (cycCnt >= CYC_LAST) begin
            cycCnt <= '0;
            if (intCnt >= INT_LAST) begin
              intCnt <= '0;
              state  <= (state == PRESS_BOUNCE) ? HELD : IDLE;
            end else begin
              intCnt <= intCnt + 1'b1;
            end
          end else begin
            cycCnt <= cycCnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_matrix_emulator.sv
// Directed bench: a clean-edge instance (dut0) and a 4-cycle x 3-interval bouncing instance (dut1).
module tb_keypad_matrix_emulator;

  logic       clk;
  logic       nreset;
  logic [3:0] cols0, cols1;
  logic [3:0] rows0, rows1;
  logic       keyActive0, keyActive1;
  logic [3:0] heldKey0, heldKey1;
  logic       busy0, busy1;
  int         checks;
  int         errors;

  keypad_matrix_emulator_if if0 ();
  keypad_matrix_emulator_if if1 ();

  keypad_matrix_emulator #(.BOUNCE_PERIOD(8), .BOUNCE_COUNT(0)) dut0 (
    .clk(clk), .nreset(nreset), .cmd(if0), .cols(cols0), .rows(rows0),
    .keyActive(keyActive0), .heldKey(heldKey0), .busy(busy0)
  );

  keypad_matrix_emulator #(.BOUNCE_PERIOD(4), .BOUNCE_COUNT(3)) dut1 (
    .clk(clk), .nreset(nreset), .cmd(if1), .cols(cols1), .rows(rows1),
    .keyActive(keyActive1), .heldKey(heldKey1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One-cycle command strobe; returns at the first negedge after the accepting edge.
  task automatic applyStimulus(input int which, input logic press, input logic [3:0] key);
    @(negedge clk);
    if (which == 0) begin
      if0.cmdValid = 1'b1; if0.cmdPress = press; if0.cmdKey = key;
    end else begin
      if1.cmdValid = 1'b1; if1.cmdPress = press; if1.cmdKey = key;
    end
    @(negedge clk);
    if0.cmdValid = 1'b0;
    if1.cmdValid = 1'b0;
  endtask

  initial begin
    logic [3:0] keyMap [16];
    logic [3:0] colVec;
    logic [3:0] expRows;
    logic       expBit;
    int         mapRow;
    int         mapCol;

    keyMap = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
               4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
    checks = 0;
    errors = 0;
    nreset = 1'b0;
    cols0 = 4'hF;
    cols1 = 4'hF;
    if0.cmdValid = 1'b0; if0.cmdPress = 1'b0; if0.cmdKey = 4'h0;
    if1.cmdValid = 1'b0; if1.cmdPress = 1'b0; if1.cmdKey = 4'h0;
    #12 nreset = 1'b1;
    @(negedge clk);

    checkOutput("resetRows", rows0, 4'hF);
    checkOutput("resetReady", if0.cmdReady, 1'b1);
    checkOutput("resetErr", if0.cmdErr, 1'b0);
    checkOutput("resetKeyActive", keyActive0, 1'b0);
    checkOutput("resetHeldKey", heldKey0, 4'h0);
    checkOutput("resetBusy", busy0, 1'b0);
    checkOutput("resetReady1", if1.cmdReady, 1'b1);

    // Clean-edge press of key 5 (row 1, col 1)
    cols0 = 4'b1101;
    applyStimulus(0, 1'b1, 4'h5);
    checkOutput("clean5Rows", rows0, 4'b1101);
    checkOutput("clean5KeyActive", keyActive0, 1'b1);
    checkOutput("clean5HeldKey", heldKey0, 4'h5);
    checkOutput("clean5Ready", if0.cmdReady, 1'b1);
    cols0 = 4'b1110;
    #1;
    checkOutput("clean5OtherCol", rows0, 4'hF);
    cols0 = 4'b1101;
    applyStimulus(0, 1'b0, 4'h0);
    checkOutput("clean5ReleaseRows", rows0, 4'hF);
    checkOutput("clean5ReleaseActive", keyActive0, 1'b0);
    checkOutput("clean5ReleaseHeld", heldKey0, 4'h5);

    // Release while idle is illegal
    applyStimulus(0, 1'b0, 4'h3);
    checkOutput("idleReleaseErr", if0.cmdErr, 1'b1);
    checkOutput("idleReleaseRows", rows0, 4'hF);
    @(negedge clk);
    checkOutput("idleReleaseErrDrop", if0.cmdErr, 1'b0);
    cols0 = 4'hF;

    // Press 'D' with bounce, with a stray command offered mid-bounce
    cols1 = 4'b0111;
    applyStimulus(1, 1'b1, 4'hD);
    for (int i = 0; i < 12; i++) begin
      expBit = (i >= 4 && i < 8) ? 1'b1 : 1'b0;
      checkOutput("pressBounceRow3", rows1[3], expBit);
      checkOutput("pressBounceReady", if1.cmdReady, 1'b0);
      checkOutput("pressBounceErr", if1.cmdErr, 1'b0);
      if (i == 5) begin
        if1.cmdValid = 1'b1; if1.cmdPress = 1'b0; if1.cmdKey = 4'h0;
      end
      if (i == 6) if1.cmdValid = 1'b0;
      @(negedge clk);
    end
    checkOutput("heldRow3", rows1[3], 1'b0);
    checkOutput("heldReady", if1.cmdReady, 1'b1);
    checkOutput("heldBusy", busy1, 1'b0);
    checkOutput("heldHeldKey", heldKey1, 4'hD);
    @(negedge clk);
    checkOutput("heldRowsSteady", rows1, 4'b0111);

    // Release 'D' with bounce
    applyStimulus(1, 1'b0, 4'h2);
    for (int i = 0; i < 12; i++) begin
      expBit = (i >= 4 && i < 8) ? 1'b0 : 1'b1;
      checkOutput("releaseBounceRow3", rows1[3], expBit);
      checkOutput("releaseBounceBusy", busy1, 1'b1);
      @(negedge clk);
    end
    checkOutput("releasedRows", rows1, 4'hF);
    checkOutput("releasedActive", keyActive1, 1'b0);
    checkOutput("releasedHeldKey", heldKey1, 4'hD);
    checkOutput("releasedReady", if1.cmdReady, 1'b1);

    // Press '0' while held on '7' is illegal
    applyStimulus(0, 1'b1, 4'h7);
    applyStimulus(0, 1'b1, 4'h0);
    checkOutput("heldPressErr", if0.cmdErr, 1'b1);
    checkOutput("heldPressKey", heldKey0, 4'h7);
    checkOutput("heldPressActive", keyActive0, 1'b1);
    applyStimulus(0, 1'b0, 4'h0);

    // Sweep every key across all four single-column scans
    for (int k = 0; k < 16; k++) begin
      mapRow = 0;
      mapCol = 0;
      for (int idx = 0; idx < 16; idx++) begin
        if (keyMap[idx] == 4'(k)) begin
          mapRow = idx / 4;
          mapCol = idx % 4;
        end
      end
      applyStimulus(0, 1'b1, 4'(k));
      for (int cc = 0; cc < 4; cc++) begin
        colVec = ~(4'b0001 << cc);
        cols0 = colVec;
        #1;
        expRows = (cc == mapCol) ? ~(4'b0001 << mapRow) : 4'hF;
        checkOutput("sweepRows", rows0, expRows);
      end
      cols0 = 4'hF;
      applyStimulus(0, 1'b0, 4'h0);
    end

    // Asynchronous reset in the middle of a press bounce
    cols1 = 4'b0111;
    applyStimulus(1, 1'b1, 4'hD);
    @(negedge clk);
    checkOutput("preResetRows", rows1, 4'b0111);
    #2 nreset = 1'b0;
    #1;
    checkOutput("asyncResetRows", rows1, 4'hF);
    checkOutput("asyncResetActive", keyActive1, 1'b0);
    @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);
    checkOutput("postResetReady", if1.cmdReady, 1'b1);
    checkOutput("postResetBusy", busy1, 1'b0);
    checkOutput("postResetHeldKey", heldKey1, 4'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_matrix_emulator.md
Name: keypad_matrix_emulator

Overview:
- Synthesizable model of a 4x4 hex keypad matrix: the responder end of the column-scan / row-sense interface that the keypad scanner drives.
- Accepts press/release commands for one key at a time and drives row lines from the scanned columns, with deterministic contact bounce on every press and release.
- Used in benches and in hardware-in-loop builds in place of the physical keypad, so the keypad decoder and debounce path can be exercised without the physical part.

Parameters:
- BOUNCE_PERIOD, 8, cycles per bounce half-interval; must be >= 1.
- BOUNCE_COUNT, 5, number of bounce intervals per press or release; 0 means a clean edge.

Ports:
- clk  input  1  system clock.
- nreset  input  1  asynchronous active-low reset.
- cols  input  4  column drive from the scanner; active-low, so 0 means that column is driven.
- rows  output  4  row sense to the scanner; active-low, idle 4'b1111 (pull-up behaviour).
- cmdValid  input  1  command strobe.
- cmdPress  input  1  1 = press, 0 = release.
- cmdKey  input  4  hex value of the key for a press; ignored on release.
- cmdReady  output  1  command accepted in a cycle where cmdValid && cmdReady.
- cmdErr  output  1  one-cycle pulse on an illegal accepted command.
- keyActive  output  1  contact currently closed, bounce included.
- heldKey  output  4  key latched at press acceptance.
- busy  output  1  bounce phase in progress.

Behaviour:
- Clock/reset: single clock clk; reset nreset is asynchronous, active-low.
- Reset values: state IDLE, contact open, rows 4'b1111, cmdReady 1, cmdErr 0, keyActive 0, heldKey 0, busy 0, counters 0.
- Key map, row-major, row0..row3 by col0..col3:
  - Row 0: 1 2 3 A
  - Row 1: 4 5 6 B
  - Row 2: 7 8 9 C
  - Row 3: E 0 F D
- The map is a combinational lookup from heldKey to (r,c).
- rows is purely combinational from cols, with zero latency, like a physical matrix:
  - rows[r] = 0 iff contact is closed and cols[c] == 0.
  - All other rows are 1.
  - Multiple low cols are legal; only column c matters.
- States:
  - IDLE: contact open.
  - PRESS_BOUNCE: on accepted press, latch heldKey and clear counters.
    - The contact is closed while the interval index is even and open while it is odd.
    - Each interval lasts BOUNCE_PERIOD cycles; there are BOUNCE_COUNT intervals.
    - Then go to HELD with the contact forced closed.
  - HELD: contact closed.
  - RELEASE_BOUNCE: on accepted release.
    - The contact is open while the interval index is even and closed while it is odd.
    - After BOUNCE_COUNT*BOUNCE_PERIOD cycles, go to IDLE with the contact forced open.
  - BOUNCE_COUNT = 0 moves directly to HELD or IDLE; the contact changes on the cycle after acceptance.
- Handshake:
  - cmdReady = 1 in IDLE and HELD, 0 in both bounce states (busy = 1 there).
  - A command is consumed on the rising edge where cmdValid && cmdReady.
  - The contact changes on the first cycle after acceptance.
- Illegal commands are accepted, change no state, and pulse cmdErr for one cycle:
  - release in IDLE;
  - press in HELD.
- A release in HELD releases heldKey regardless of cmdKey.
- Counters:
  - Cycle counter width $clog2(BOUNCE_PERIOD+1).
  - Interval counter width $clog2(BOUNCE_COUNT+1).
  - Both saturate-safe and cleared on every state entry.
- heldKey holds its value through IDLE after release, until the next accepted press.
- Reset mid-bounce or while HELD: immediate return to the reset values; rows go to 4'b1111 asynchronously.

Test Plan:
- Reset, then press key 5 with BOUNCE_COUNT=0 and cols=4'b1101 → rows=4'b1101 from the next cycle; cols=4'b1110 → rows=4'b1111.
- BOUNCE_PERIOD=4, BOUNCE_COUNT=3, press 'D', hold cols=4'b0111:
  - rows[3] sequence is 0×4, 1×4, 0×4, then 0 steady;
  - cmdReady=0 for exactly 12 cycles;
  - then HELD with busy=0.
- From HELD on 'D', release with the same parameters → rows[3] sequence 1×4, 0×4, 1×4, then 1 steady; state IDLE; heldKey still 4'hD.
- Illegal commands:
  - release in IDLE → cmdErr pulses 1 cycle and rows stay 4'hF;
  - press '0' while HELD on '7' → cmdErr pulses, heldKey stays 4'h7;
  - cmdValid during bounce → not accepted, no cmdErr.
- Sweep all 16 keys with cols rotating 1110→1101→1011→0111 → exactly one row is low in exactly the mapped column slot per key.
- Assert nreset mid PRESS_BOUNCE → rows=4'hF and keyActive=0 without a clock edge; cmdReady=1 after release of reset.
